// File: rtl/ram_wr_sched_pkg.sv
// Shared types and default sizing for the multi-channel RAM write scheduler.
package ram_wr_sched_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DW     = 8;
    localparam int DEF_AW     = 9;
    localparam int DEF_BURST  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARB,
        ST_BURST,
        ST_DRAIN
    } state_e;

endpackage

// File: rtl/ram_wr_sched_rr_arbiter.sv
// Round-robin picker: grants the first requester at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int j;

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        j       = 0;
        // Scan from the farthest candidate back to ptr_i so the nearest requester wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req_i[IW'(j)]) begin
                idx_o   = IW'(j);
                valid_o = 1'b1;
            end
        end
        if (valid_o) begin
            gnt_o[idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/ram_wr_sched.sv
// Moves bursts from per-channel FIFOs into private regions of one shared RAM,
// one channel at a time, chosen round-robin among channels reporting almost_full.
module ram_wr_sched
    import ram_wr_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int BURST  = DEF_BURST
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_almost_full,
    input  logic [NUM_CH-1:0]    ch_empty,
    input  logic [NUM_CH*DW-1:0] ch_rd_data,
    output logic [NUM_CH-1:0]    ch_rd_en,
    output logic                 ram_wr_en,
    output logic [AW-1:0]        ram_wr_addr,
    output logic [DW-1:0]        ram_wr_data,
    output logic [NUM_CH-1:0]    grant,
    output logic [NUM_CH-1:0]    region_done,
    output logic                 busy
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OW = AW - $clog2(NUM_CH);
    localparam int CW = $clog2(BURST + 1);

    state_e        state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] gidx_q, gidx_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en_q;
    logic [OW-1:0] offset_q [NUM_CH];

    logic [NUM_CH-1:0] arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_valid;
    logic              rd_go;
    logic [OW-1:0]     cur_off;

    rr_arbiter #(
        .N  (NUM_CH),
        .IW (IW)
    ) u_arb (
        .req_i   (ch_almost_full),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign rd_go   = (state_q == ST_BURST) && !ch_empty[gidx_q] && (cnt_q < CW'(BURST));
    assign cur_off = offset_q[gidx_q];

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|ch_almost_full) begin
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                // A request that vanished before arbitration simply returns to idle.
                if (arb_valid) begin
                    state_d  = ST_BURST;
                    gidx_d   = arb_idx;
                    cnt_d    = '0;
                    rr_ptr_d = (arb_idx == IW'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (rd_go) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(BURST - 1)) begin
                        state_d = ST_DRAIN;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = (|ch_almost_full) ? ST_ARB : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ch_rd_en            = '0;
        grant               = '0;
        region_done         = '0;
        ch_rd_en[gidx_q]    = rd_go;
        region_done[gidx_q] = wr_en_q && (&cur_off);
        case (state_q)
            ST_ARB:             grant = arb_gnt;
            ST_BURST, ST_DRAIN: grant[gidx_q] = 1'b1;
            default:            grant = '0;
        endcase
    end

    // The write lands one cycle after its read, when the FIFO data becomes valid.
    assign ram_wr_en   = wr_en_q;
    assign ram_wr_addr = wr_en_q ? ((AW'(gidx_q) << OW) | AW'(cur_off)) : '0;
    assign ram_wr_data = wr_en_q ? ch_rd_data[int'(gidx_q) * DW +: DW] : '0;
    assign busy        = (state_q != ST_IDLE);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            cnt_q    <= '0;
            wr_en_q  <= 1'b0;
            // NOTE: the offset array is small flops, not RAM, so it is reset to restart every region at its base.
            for (int i = 0; i < NUM_CH; i++) begin
                offset_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            cnt_q    <= cnt_d;
            wr_en_q  <= rd_go;
            if (wr_en_q) begin
                offset_q[gidx_q] <= cur_off + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ram_wr_sched.sv
// Self-checking bench: behavioural FIFOs plus a burst-level timeline model of the scheduler.
module tb_ram_wr_sched;

    localparam int NUM_CH = 4;
    localparam int DW     = 8;
    localparam int AW     = 9;
    localparam int BURST  = 16;
    localparam int REGION = (1 << AW) / NUM_CH;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_CH-1:0]    ch_almost_full;
    logic [NUM_CH-1:0]    ch_empty;
    logic [NUM_CH*DW-1:0] ch_rd_data;
    logic [NUM_CH-1:0]    ch_rd_en;
    logic                 ram_wr_en;
    logic [AW-1:0]        ram_wr_addr;
    logic [DW-1:0]        ram_wr_data;
    logic [NUM_CH-1:0]    grant;
    logic [NUM_CH-1:0]    region_done;
    logic                 busy;

    ram_wr_sched #(
        .NUM_CH (NUM_CH),
        .DW     (DW),
        .AW     (AW),
        .BURST  (BURST)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ch_almost_full (ch_almost_full),
        .ch_empty       (ch_empty),
        .ch_rd_data     (ch_rd_data),
        .ch_rd_en       (ch_rd_en),
        .ram_wr_en      (ram_wr_en),
        .ram_wr_addr    (ram_wr_addr),
        .ram_wr_data    (ram_wr_data),
        .grant          (grant),
        .region_done    (region_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Bench-side FIFOs and the stream of words each channel should write, in order.
    logic [DW-1:0] fifo_q [NUM_CH][$];
    logic [DW-1:0] ref_q  [NUM_CH][$];
    logic [DW-1:0] rd_data_r [NUM_CH];

    // Expected per-cycle timeline of the current grant, built at arbitration time.
    typedef struct {
        int ch;
        bit rd;
        bit drain;
    } slot_t;
    slot_t plan_q[$];

    int          rr_m       = 0;
    bit          pend_arb_m = 1'b0;
    int          wr_pend_ch = -1;
    int          wcount_m [NUM_CH];
    bit          rand_push_en = 1'b0;
    logic [NUM_CH-1:0] rd_seen = '0;
    bit          rst_seen = 1'b0;

    // Observation records used by the directed scenarios.
    int                wr_obs [NUM_CH];
    int                rd_obs [NUM_CH];
    int                first_addr [NUM_CH];
    int                last_addr [NUM_CH];
    logic [NUM_CH-1:0] gseq[$];
    logic [NUM_CH-1:0] prev_grant;
    int                done_addr;
    int                next_addr;
    logic [NUM_CH-1:0] done_val;
    bit                watch_next;
    logic [30:0]       obs_all;

    task automatic drive_fifo();
        for (int i = 0; i < NUM_CH; i++) begin
            ch_empty[i]             = (fifo_q[i].size() == 0);
            ch_rd_data[i*DW +: DW]  = rd_data_r[i];
        end
    endtask

    task automatic push(input int ch, input logic [DW-1:0] v);
        fifo_q[ch].push_back(v);
        ref_q[ch].push_back(v);
        drive_fifo();
    endtask

    function automatic int pick(input logic [NUM_CH-1:0] req);
        for (int k = 0; k < NUM_CH; k++)
            if (req[(rr_m + k) % NUM_CH]) return (rr_m + k) % NUM_CH;
        return -1;
    endfunction

    task automatic clear_mon();
        for (int i = 0; i < NUM_CH; i++) begin
            wr_obs[i] = 0; rd_obs[i] = 0; first_addr[i] = -1; last_addr[i] = -1;
        end
        gseq.delete();
        prev_grant = '0; done_addr = -1; next_addr = -1; done_val = '0; watch_next = 1'b0;
    endtask

    task automatic model_eval();
        logic [NUM_CH-1:0] e_grant, e_rd, e_done;
        logic              e_busy, e_wr;
        logic [AW-1:0]     e_addr;
        logic [DW-1:0]     e_data;
        int                g, k, off, rd_ch, c;
        slot_t             s;
        e_grant = '0; e_rd = '0; e_done = '0; e_busy = 1'b0; e_wr = 1'b0;
        e_addr = '0; e_data = '0; rd_ch = -1;

        if (plan_q.size() == 0) begin
            if (pend_arb_m) begin
                pend_arb_m = 1'b0;
                e_busy = 1'b1;
                g = pick(ch_almost_full);
                if (g >= 0) begin
                    e_grant = NUM_CH'(1) << g;
                    rr_m = (g + 1) % NUM_CH;
                    k = (fifo_q[g].size() < BURST) ? fifo_q[g].size() : BURST;
                    for (int n = 0; n < k; n++) plan_q.push_back('{ch: g, rd: 1'b1, drain: 1'b0});
                    if (k < BURST) plan_q.push_back('{ch: g, rd: 1'b0, drain: 1'b0});
                    plan_q.push_back('{ch: g, rd: 1'b0, drain: 1'b1});
                end
            end else begin
                pend_arb_m = |ch_almost_full;
            end
        end else begin
            s = plan_q.pop_front();
            e_busy  = 1'b1;
            e_grant = NUM_CH'(1) << s.ch;
            if (s.rd) begin
                e_rd  = NUM_CH'(1) << s.ch;
                rd_ch = s.ch;
            end
            if (s.drain) pend_arb_m = |ch_almost_full;
        end

        if (wr_pend_ch >= 0) begin
            g      = wr_pend_ch;
            e_wr   = 1'b1;
            e_data = (ref_q[g].size() > 0) ? ref_q[g].pop_front() : '0;
            off    = wcount_m[g] % REGION;
            e_addr = AW'(g * REGION + off);
            e_done = (off == REGION - 1) ? (NUM_CH'(1) << g) : '0;
            wcount_m[g]++;
        end
        wr_pend_ch = rd_ch;

        check("ch_rd_en",    ch_rd_en,    e_rd);
        check("grant",       grant,       e_grant);
        check("busy",        busy,        e_busy);
        check("ram_wr_en",   ram_wr_en,   e_wr);
        check("ram_wr_addr", ram_wr_addr, e_addr);
        check("ram_wr_data", ram_wr_data, e_data);
        check("region_done", region_done, e_done);

        obs_all = {ch_rd_en, ram_wr_en, ram_wr_addr, ram_wr_data, grant, region_done, busy};
        if (ram_wr_en) begin
            c = int'(ram_wr_addr) / REGION;
            wr_obs[c]++;
            if (first_addr[c] < 0) first_addr[c] = int'(ram_wr_addr);
            last_addr[c] = int'(ram_wr_addr);
            if (watch_next) begin
                next_addr  = int'(ram_wr_addr);
                watch_next = 1'b0;
            end
            if (region_done != '0) begin
                done_addr  = int'(ram_wr_addr);
                done_val   = region_done;
                watch_next = 1'b1;
            end
        end
        if (grant != '0 && grant != prev_grant) gseq.push_back(grant);
        prev_grant = grant;
        for (int i = 0; i < NUM_CH; i++) if (ch_rd_en[i]) rd_obs[i]++;
        rd_seen  = ch_rd_en;
        rst_seen = rst;
    endtask

    task automatic post_edge();
        int owner;
        if (rst_seen) begin
            plan_q.delete();
            pend_arb_m = 1'b0;
            rr_m = 0;
            for (int i = 0; i < NUM_CH; i++) wcount_m[i] = 0;
            // A read issued in the reset cycle still consumed a word that will never be written.
            if (wr_pend_ch >= 0 && ref_q[wr_pend_ch].size() > 0) void'(ref_q[wr_pend_ch].pop_front());
            wr_pend_ch = -1;
        end
        for (int i = 0; i < NUM_CH; i++)
            if (rd_seen[i] && fifo_q[i].size() > 0) rd_data_r[i] = fifo_q[i].pop_front();
        if (rand_push_en) begin
            owner = (plan_q.size() > 0) ? plan_q[0].ch : -1;
            for (int i = 0; i < NUM_CH; i++)
                if (i != owner && fifo_q[i].size() < 40 && $urandom_range(0, 3) == 0)
                    push(i, DW'($urandom));
        end
        drive_fifo();
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
        post_edge();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ch_almost_full = '0;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            fifo_q[i].delete();
            ref_q[i].delete();
            rd_data_r[i] = '0;
        end
        drive_fifo();
        clear_mon();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NUM_CH-1:0] exp_order [5];
        logic [NUM_CH-1:0] got_g;
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst = 1'b1;
        ch_almost_full = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rd_data_r[i] = '0;
            wcount_m[i]  = 0;
        end
        drive_fifo();
        clear_mon();

        do_reset();
        check("reset_outputs", obs_all, 0);

        // Single channel with more data than one burst.
        for (int v = 0; v < 32; v++) push(0, DW'(v));
        ch_almost_full = 4'b0001;
        step(); step();
        ch_almost_full = '0;
        repeat (30) step();
        check("s1_writes", wr_obs[0], 16);
        check("s1_first_addr", first_addr[0], 0);
        check("s1_last_addr", last_addr[0], 15);
        check("s1_idle", busy, 0);

        // Short FIFO ends the burst early; offset resumes where it stopped.
        do_reset();
        for (int v = 0; v < 5; v++) push(1, DW'(8'h50 + v));
        ch_almost_full = 4'b0010;
        step(); step();
        ch_almost_full = '0;
        repeat (20) step();
        check("s2_writes", wr_obs[1], 5);
        check("s2_first_addr", first_addr[1], 128);
        check("s2_last_addr", last_addr[1], 132);
        push(1, 8'hAA);
        ch_almost_full = 4'b0010;
        step(); step();
        ch_almost_full = '0;
        repeat (10) step();
        check("s2_resume_addr", last_addr[1], 133);

        // All channels requesting: round-robin order.
        do_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int v = 0; v < 20; v++) push(c, DW'(c * 32 + v));
        ch_almost_full = '1;
        for (int t = 0; t < 200 && gseq.size() < 5; t++) step();
        ch_almost_full = '0;
        check("s3_grants_seen", gseq.size() >= 5, 1);
        for (int i = 0; i < 5; i++) begin
            got_g = (i < gseq.size()) ? gseq[i] : '0;
            check($sformatf("s3_grant%0d", i), got_g, exp_order[i]);
        end
        check("s3_ch2_base", first_addr[2], 256);
        repeat (80) step();

        // Region wrap on channel 3.
        do_reset();
        for (int v = 0; v < 9 * BURST; v++) push(3, DW'(v));
        ch_almost_full = 4'b1000;
        for (int t = 0; t < 400 && next_addr < 0; t++) step();
        ch_almost_full = '0;
        check("s4_done_addr", done_addr, 511);
        check("s4_done_ch", done_val, 4'b1000);
        check("s4_wrap_addr", next_addr, 384);
        repeat (40) step();

        // Reset in the 7th cycle of a burst.
        do_reset();
        for (int v = 0; v < 30; v++) push(2, DW'(8'hC0 + v));
        ch_almost_full = 4'b0100;
        for (int t = 0; t < 100 && rd_obs[2] < 6; t++) step();
        check("s5_reached_burst", rd_obs[2] >= 6, 1);
        rst = 1'b1;
        ch_almost_full = '0;
        step();
        rst = 1'b0;
        step();
        check("s5_outputs_zero", obs_all, 0);
        clear_mon();
        ch_almost_full = 4'b0100;
        step(); step();
        ch_almost_full = '0;
        for (int t = 0; t < 40 && first_addr[2] < 0; t++) step();
        check("s5_restart_addr", first_addr[2], 256);
        repeat (30) step();

        // Randomised traffic with one reset in the middle.
        do_reset();
        rand_push_en = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            if ($urandom_range(0, 7) == 0) ch_almost_full = NUM_CH'($urandom_range(0, 15));
            rst = (t == 1500);
            step();
        end
        rst = 1'b0;
        rand_push_en = 1'b0;
        ch_almost_full = '0;
        repeat (60) step();
        check("s6_idle_end", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
